noncoh_acc_bfp: RTL and testbench

Parametrised block-floating-point non-coherent accumulator for the acquisition engine. It takes per-round coherent amplitude vectors, one vector of FREQ_NUM bins per code position, over a valid/ready handshake. It accumulates them into an external simple-dual-port non-coherent RAM with a shared exponent and automatic rescaling on overflow. On the last round it reports the peak bin and, optionally, the noise floor.

---
 rtl/noncoh_acc_bfp_if.sv | 47 ++++
 rtl/noncoh_acc_bfp.sv | 258 +++++++++++++++++++++++++
 tb/tb_noncoh_acc_bfp.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/noncoh_acc_bfp_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noncoh_acc_bfp_if : handshake, RAM and report bus of noncoh_acc_bfp       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface noncoh_acc_bfp_if #(
  parameter int ADDR_W   = 10,
  parameter int FREQ_NUM = 8,
  parameter int AMP_W    = 8,
  parameter int NF_W     = 18
);
  logic                      round_start;
  logic                      first_round;
  logic                      last_round;
  logic [3:0]                coh_exp;
  logic                      coh_valid;
  logic                      coh_ready;
  logic [FREQ_NUM*AMP_W-1:0] coh_data;
  logic                      mem_rd;
  logic [ADDR_W-1:0]         mem_raddr;
  logic [FREQ_NUM*AMP_W-1:0] mem_rdata;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_waddr;
  logic [FREQ_NUM*AMP_W-1:0] mem_wdata;
  logic                      busy;
  logic                      peak_valid;
  logic [AMP_W:0]            peak_amp;
  logic [ADDR_W-1:0]         peak_pos;
  logic [3:0]                peak_freq;
  logic [3:0]                peak_exp;
  logic [NF_W-1:0]           noise_floor;

  modport master (
    output round_start, first_round, last_round, coh_exp, coh_valid, coh_data,
           mem_rdata,
    input  coh_ready, mem_rd, mem_raddr, mem_we, mem_waddr, mem_wdata, busy,
           peak_valid, peak_amp, peak_pos, peak_freq, peak_exp, noise_floor
  );

  modport slave (
    input  round_start, first_round, last_round, coh_exp, coh_valid, coh_data,
           mem_rdata,
    output coh_ready, mem_rd, mem_raddr, mem_we, mem_waddr, mem_wdata, busy,
           peak_valid, peak_amp, peak_pos, peak_freq, peak_exp, noise_floor
  );
endinterface
`default_nettype wire

// File: rtl/noncoh_acc_bfp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noncoh_acc_bfp : block-floating-point non-coherent accumulator with peak  |
// | search; noise floor built only when NONCOH_NOISE_FLOOR_EN is defined.    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module noncoh_acc_bfp #(
  parameter int DEPTH    = 682,
  parameter int ADDR_W   = 10,
  parameter int FREQ_NUM = 8,
  parameter int AMP_W    = 8,
  parameter int NF_W     = 18
) (
  input  logic             clk,
  input  logic             rst_b,
  noncoh_acc_bfp_if.slave  bus
);

  localparam logic [4:0]        c_AMP_SH   = 5'(AMP_W);
  localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  typedef logic [AMP_W:0] sum_t;

  // Round-half-up right shift; shifts of AMP_W or more flush to zero.
  function automatic sum_t f_rshr(input sum_t x, input logic [4:0] k);
    sum_t r;
    if (k == 5'd0)          r = x;
    else if (k >= c_AMP_SH) r = '0;
    else                    r = (x >> k) + ((x >> (k - 5'd1)) & sum_t'(1));
    return r;
  endfunction

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic              drain_q;
  logic [3:0]        e_q, nshift_q, cshift_q;
  logic              first_q, last_q;
  logic              xs_sticky_q, pend_q;
  logic [ADDR_W-1:0] exc_pos_q, pend_pos_q;

  logic                      s1_vld_q, s2_vld_q;
  logic [ADDR_W-1:0]         s1_addr_q, s2_addr_q;
  logic [FREQ_NUM*AMP_W-1:0] s1_coh_q;
  logic [FREQ_NUM-1:0][AMP_W:0] s2_sum_q;

  logic [AMP_W:0]    pk_amp_q, out_amp_q;
  logic [ADDR_W-1:0] pk_pos_q, out_pos_q;
  logic [3:0]        pk_freq_q, out_freq_q, out_exp_q;

  logic                         w_accept;
  logic [4:0]                   w_nsh;
  logic [FREQ_NUM-1:0][AMP_W:0] w_sum;
  logic [FREQ_NUM-1:0]          w_ovf_bin;
  logic                         w_ovf_wr, w_xs;
  logic [AMP_W:0]               w_pk_amp;
  logic [ADDR_W-1:0]            w_pk_pos;
  logic [3:0]                   w_pk_freq;

  assign w_accept = bus.coh_valid & (state_q == ST_RUN);

  // Entries below the previous round's overflow point still carry the old exponent.
  assign w_nsh = {1'b0, nshift_q} + {4'd0, (pend_q && (s1_addr_q < pend_pos_q))};

  assign w_ovf_wr = s2_vld_q & ~last_q & (e_q != 4'hF) & (|w_ovf_bin);
  assign w_xs     = xs_sticky_q | w_ovf_wr;

  generate
    for (genvar k = 0; k < FREQ_NUM; k++) begin : g_bin
      logic [AMP_W-1:0] w_rd, w_half, w_wbin;
      assign w_rd     = first_q ? '0 : bus.mem_rdata[k*AMP_W +: AMP_W];
      assign w_sum[k] = f_rshr({1'b0, w_rd}, w_nsh)
                      + f_rshr({1'b0, s1_coh_q[k*AMP_W +: AMP_W]}, {1'b0, cshift_q});
      assign w_ovf_bin[k] = s2_sum_q[k][AMP_W];
      assign w_half       = AMP_W'(f_rshr(s2_sum_q[k], 5'd1));
      always_comb begin
        w_wbin = s2_sum_q[k][AMP_W-1:0];
        if (e_q == 4'hF) begin
          if (s2_sum_q[k][AMP_W]) w_wbin = '1;
        end else if (w_xs) begin
          w_wbin = w_half;
        end
      end
      assign bus.mem_wdata[k*AMP_W +: AMP_W] = w_wbin;
    end
  endgenerate

  // Strict compare in ascending bin order keeps the lowest address/bin on ties.
  always_comb begin
    w_pk_amp  = pk_amp_q;
    w_pk_pos  = pk_pos_q;
    w_pk_freq = pk_freq_q;
    if (s2_vld_q && last_q) begin
      for (int k = 0; k < FREQ_NUM; k++) begin
        if (s2_sum_q[k] > w_pk_amp) begin
          w_pk_amp  = s2_sum_q[k];
          w_pk_pos  = s2_addr_q;
          w_pk_freq = 4'(k);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_vld_q  <= 1'b0;
      s1_addr_q <= '0;
      s1_coh_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s2_sum_q  <= '0;
    end else begin
      s1_vld_q  <= w_accept;
      s1_addr_q <= idx_q;
      s1_coh_q  <= bus.coh_data;
      s2_vld_q  <= s1_vld_q;
      s2_addr_q <= s1_addr_q;
      s2_sum_q  <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      drain_q     <= 1'b0;
      e_q         <= '0;
      nshift_q    <= '0;
      cshift_q    <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      xs_sticky_q <= 1'b0;
      pend_q      <= 1'b0;
      exc_pos_q   <= '0;
      pend_pos_q  <= '0;
      pk_amp_q    <= '0;
      pk_pos_q    <= '0;
      pk_freq_q   <= '0;
      out_amp_q   <= '0;
      out_pos_q   <= '0;
      out_freq_q  <= '0;
      out_exp_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.round_start) begin
            state_q     <= ST_RUN;
            idx_q       <= '0;
            first_q     <= bus.first_round;
            last_q      <= bus.last_round;
            pend_q      <= xs_sticky_q & ~bus.first_round;
            pend_pos_q  <= exc_pos_q;
            xs_sticky_q <= 1'b0;
            pk_amp_q    <= '0;
            pk_pos_q    <= '0;
            pk_freq_q   <= '0;
            if (bus.first_round) begin
              e_q      <= bus.coh_exp;
              nshift_q <= '0;
              cshift_q <= '0;
            end else if (bus.coh_exp > e_q) begin
              e_q      <= bus.coh_exp;
              nshift_q <= bus.coh_exp - e_q;
              cshift_q <= '0;
            end else begin
              nshift_q <= '0;
              cshift_q <= e_q - bus.coh_exp;
            end
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            idx_q <= idx_q + 1'b1;
            if (idx_q == c_LAST_IDX) begin
              state_q <= ST_DRAIN;
              drain_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (!drain_q) begin
            drain_q <= 1'b1;
          end else if (last_q) begin
            state_q    <= ST_REPORT;
            out_amp_q  <= w_pk_amp;
            out_pos_q  <= w_pk_pos;
            out_freq_q <= w_pk_freq;
            out_exp_q  <= e_q;
          end else begin
            state_q <= ST_IDLE;
            if (w_xs) e_q <= e_q + 4'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (w_ovf_wr && !xs_sticky_q) begin
        xs_sticky_q <= 1'b1;
        exc_pos_q   <= s2_addr_q;
      end
      if (s2_vld_q && last_q) begin
        pk_amp_q  <= w_pk_amp;
        pk_pos_q  <= w_pk_pos;
        pk_freq_q <= w_pk_freq;
      end
    end
  end

`ifdef NONCOH_NOISE_FLOOR_EN
  localparam int c_LOG_F  = $clog2(FREQ_NUM);
  localparam int c_BSUM_W = AMP_W + 1 + c_LOG_F;

  logic [c_BSUM_W-1:0] w_bsum;
  logic [NF_W:0]       w_nf_add;
  logic [NF_W-1:0]     nf_q;

  always_comb begin
    w_bsum = '0;
    for (int k = 0; k < FREQ_NUM; k++) w_bsum = w_bsum + c_BSUM_W'(s2_sum_q[k]);
  end

  assign w_nf_add = {1'b0, nf_q} + (NF_W+1)'(w_bsum >> c_LOG_F);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      nf_q <= '0;
    end else if (state_q == ST_IDLE && bus.round_start && bus.last_round) begin
      nf_q <= '0;
    end else if (s2_vld_q && last_q) begin
      nf_q <= w_nf_add[NF_W] ? '1 : w_nf_add[NF_W-1:0];
    end
  end

  assign bus.noise_floor = nf_q;
`else
  assign bus.noise_floor = '0;
`endif

  assign bus.coh_ready  = (state_q == ST_RUN);
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.mem_rd     = w_accept;
  assign bus.mem_raddr  = idx_q;
  assign bus.mem_we     = s2_vld_q & ~last_q;
  assign bus.mem_waddr  = s2_addr_q;
  assign bus.peak_valid = (state_q == ST_REPORT);
  assign bus.peak_amp   = out_amp_q;
  assign bus.peak_pos   = out_pos_q;
  assign bus.peak_freq  = out_freq_q;
  assign bus.peak_exp   = out_exp_q;

endmodule
`default_nettype wire

// File: tb/tb_noncoh_acc_bfp.sv
`default_nettype none
// Testbench for noncoh_acc_bfp: randomized and directed rounds against a
// round-level reference model with a write/peak scoreboard.
module tb_noncoh_acc_bfp;
  localparam int DEPTH    = 4;
  localparam int ADDR_W   = 2;
  localparam int FREQ_NUM = 4;
  localparam int AMP_W    = 8;
  localparam int NF_W     = 18;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  noncoh_acc_bfp_if #(.ADDR_W(ADDR_W), .FREQ_NUM(FREQ_NUM), .AMP_W(AMP_W), .NF_W(NF_W)) bus ();

  noncoh_acc_bfp #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FREQ_NUM(FREQ_NUM), .AMP_W(AMP_W), .NF_W(NF_W))
    dut (.clk(clk), .rst_b(rst_b), .bus(bus));

  logic [FREQ_NUM*AMP_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_raddr];
    if (bus.mem_we) ram[bus.mem_waddr] <= bus.mem_wdata;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_t = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; logic [FREQ_NUM*AMP_W-1:0] data; } wr_t;
  typedef struct { int amp; int pos; int freq; int exp; int nf; } pk_t;
  wr_t wq[$];
  pk_t pq[$];

  int  m_ram [DEPTH][FREQ_NUM];
  int  m_e = 0;
  bit  m_pend = 0;
  int  m_ppos = 0;
  int  beat [DEPTH][FREQ_NUM];

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic int rsh(input int x, input int k);
    if (k == 0) return x;
    if (k >= AMP_W) return 0;
    return (x >> k) + ((x >> (k - 1)) & 1);
  endfunction

  // Whole-round reference: alignment, accumulation, rescale and peak/noise.
  task automatic model_round(input bit first, input bit last, input int ce);
    int ns, cs, ne, rd, v, exc, best, bpos, bfreq, nf, tot;
    int s [FREQ_NUM];
    bit sticky, ovf;
    wr_t w;
    pk_t p;
    if (first) begin m_e = ce; ns = 0; cs = 0; m_pend = 0; end
    else if (ce > m_e) begin ns = ce - m_e; m_e = ce; cs = 0; end
    else begin cs = m_e - ce; ns = 0; end
    sticky = 0; exc = 0; best = -1; bpos = 0; bfreq = 0; nf = 0;
    for (int a = 0; a < DEPTH; a++) begin
      ovf = 0; tot = 0;
      for (int k = 0; k < FREQ_NUM; k++) begin
        rd = first ? 0 : m_ram[a][k];
        ne = ns + ((m_pend && a < m_ppos) ? 1 : 0);
        s[k] = rsh(rd, ne) + rsh(beat[a][k], cs);
        if (s[k] >= (1 << AMP_W)) ovf = 1;
        tot += s[k];
      end
      if (last) begin
        for (int k = 0; k < FREQ_NUM; k++)
          if (s[k] > best) begin best = s[k]; bpos = a; bfreq = k; end
        nf += tot / FREQ_NUM;
        if (nf > (1 << NF_W) - 1) nf = (1 << NF_W) - 1;
      end else begin
        w.addr = a;
        w.data = '0;
        for (int k = 0; k < FREQ_NUM; k++) begin
          if (m_e == 15) v = (s[k] > 255) ? 255 : s[k];
          else if (sticky || ovf) v = rsh(s[k], 1);
          else v = s[k];
          m_ram[a][k] = v;
          w.data[k*AMP_W +: AMP_W] = AMP_W'(v);
        end
        wq.push_back(w);
        if (ovf && !sticky && m_e != 15) begin sticky = 1; exc = a; end
      end
    end
    if (last) begin
      p.amp = best; p.pos = bpos; p.freq = bfreq; p.exp = m_e;
`ifdef NONCOH_NOISE_FLOOR_EN
      p.nf = nf;
`else
      p.nf = 0;
`endif
      pq.push_back(p);
      m_pend = 0;
    end else begin
      m_pend = sticky;
      m_ppos = exc;
      if (sticky) m_e++;
    end
  endtask

  // gap: 0 none, 1 random stalls with stray round_start, 2 fixed 3-cycle stall.
  task automatic drive_round(input bit first, input bit last, input int ce, input int gap);
    bit rdy;
    int t, n;
    model_round(first, last, ce);
    bus.round_start = 1'b1;
    bus.first_round = first;
    bus.last_round  = last;
    bus.coh_exp     = 4'(ce);
    @(posedge clk); #1;
    bus.round_start = 1'b0;
    bus.first_round = 1'($urandom_range(0, 1));
    bus.last_round  = 1'($urandom_range(0, 1));
    bus.coh_exp     = 4'($urandom_range(0, 15));
    t = cyc;
    for (int b = 0; b < DEPTH; b++) begin
      n = (gap == 1) ? $urandom_range(0, 3) : ((gap == 2 && b == 2) ? 3 : 0);
      bus.coh_valid = 1'b0;
      for (int g = 0; g < n; g++) begin
        bus.round_start = (g == 0 && gap != 0);
        bus.first_round = 1'b1;
        bus.last_round  = 1'b1;
        bus.coh_exp     = 4'd15;
        @(posedge clk); #1;
        bus.round_start = 1'b0;
      end
      bus.coh_valid = 1'b1;
      for (int k = 0; k < FREQ_NUM; k++) bus.coh_data[k*AMP_W +: AMP_W] = AMP_W'(beat[b][k]);
      rdy = 1'b0;
      for (int w = 0; w < 20 && !rdy; w++) begin
        rdy = bus.coh_ready;
        t = cyc;
        @(posedge clk); #1;
      end
      if (!rdy) chk("beat_accept_timeout", 0, 1);
    end
    bus.coh_valid = 1'b0;
    last_t = t;
    for (int w = 0; w < 20 && bus.busy; w++) begin
      @(posedge clk); #1;
    end
    chk("round_done_idle", bus.busy, 0);
  endtask

  task automatic fill(input int v);
    for (int a = 0; a < DEPTH; a++)
      for (int k = 0; k < FREQ_NUM; k++) beat[a][k] = v;
  endtask

  always @(negedge clk) begin
    if (rst_b) begin
      if (bus.mem_we) begin
        chk("write_expected", int'(wq.size() > 0), 1);
        if (wq.size() > 0) begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", bus.mem_waddr, w.addr);
          chk("wr_data", bus.mem_wdata, w.data);
        end
      end
      if (bus.peak_valid) begin
        chk("peak_expected", int'(pq.size() > 0), 1);
        if (pq.size() > 0) begin
          pk_t p;
          p = pq.pop_front();
          chk("peak_amp", bus.peak_amp, p.amp);
          chk("peak_pos", bus.peak_pos, p.pos);
          chk("peak_freq", bus.peak_freq, p.freq);
          chk("peak_exp", bus.peak_exp, p.exp);
          chk("noise_floor", bus.noise_floor, p.nf);
          chk("peak_latency", cyc, last_t + 3);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit f, l;
    bus.round_start = 1'b0;
    bus.first_round = 1'b0;
    bus.last_round  = 1'b0;
    bus.coh_exp     = 4'd0;
    bus.coh_valid   = 1'b0;
    bus.coh_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_coh_ready", bus.coh_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_peak_valid", bus.peak_valid, 0);
    chk("rst_peak_amp", bus.peak_amp, 0);
    chk("rst_peak_pos", bus.peak_pos, 0);
    chk("rst_peak_freq", bus.peak_freq, 0);
    chk("rst_peak_exp", bus.peak_exp, 0);
    chk("rst_noise_floor", bus.noise_floor, 0);
    rst_b = 1'b1;
    @(posedge clk); #1;

    fill(10); beat[2][1] = 200;
    drive_round(1, 1, 2, 0);

    fill(80); drive_round(1, 0, 0, 0);
    fill(40); drive_round(0, 1, 1, 0);

    fill(100); beat[1][0] = 200; drive_round(1, 0, 0, 0);
    fill(100); drive_round(0, 0, 0, 0);
    fill(0);   drive_round(0, 1, 1, 0);

    for (int a = 0; a < DEPTH; a++)
      for (int k = 0; k < FREQ_NUM; k++) beat[a][k] = $urandom_range(0, 200);
    drive_round(1, 0, 3, 2);
    drive_round(0, 0, 5, 2);
    drive_round(0, 1, 4, 2);

    fill(200); drive_round(1, 0, 15, 0);
    drive_round(0, 0, 15, 0);
    fill(90);  drive_round(0, 1, 10, 0);

    for (int r = 0; r < 30; r++) begin
      f = (r == 0) || ($urandom_range(0, 5) == 0);
      l = ($urandom_range(0, 3) == 0);
      for (int a = 0; a < DEPTH; a++)
        for (int k = 0; k < FREQ_NUM; k++)
          beat[a][k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 120);
      drive_round(f, l, $urandom_range(0, 6), $urandom_range(0, 1));
    end

    fill(16); drive_round(1, 1, 0, 0);

    #3;
    rst_b = 1'b0;
    #1;
    chk("async_rst_peak_amp", bus.peak_amp, 0);
    chk("async_rst_peak_exp", bus.peak_exp, 0);
    chk("async_rst_busy", bus.busy, 0);
    m_e = 0; m_pend = 0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    fill(5); beat[3][2] = 7;
    drive_round(1, 1, 6, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("writes_drained", wq.size(), 0);
    chk("peaks_drained", pq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
